// File: rtl/ram_pkg.sv
// +--------------------------------------------------------------------+
// | ram_pkg: shared types and helpers for param_ram_init               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package ram_pkg;

   // Init ramp is accumulated at least this wide before truncation to DATA_W.
   localparam int INIT_VAL_W = 32;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << w) < 64'(value)) w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_init_seq.sv
// +--------------------------------------------------------------------+
// | ram_init_seq: INIT/RUN FSM and arithmetic-ramp preload generator   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module ram_init_seq
   import ram_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 10,
   parameter int INIT_START = 10,
   parameter int INIT_LEN   = 50,
   parameter int INIT_BASE  = -250,
   parameter int INIT_STEP  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init_req,
   output logic              ready,
   output logic              init_done,
   output logic              init_we,
   output logic [ADDR_W-1:0] init_addr,
   output logic [DATA_W-1:0] init_data
);

   localparam int VAL_W = (DATA_W > INIT_VAL_W) ? DATA_W : INIT_VAL_W;
   localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'((INIT_LEN > 0) ? INIT_LEN - 1 : 0);
   localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(INIT_START);
   localparam logic signed [VAL_W-1:0] BASE_VAL = VAL_W'(INIT_BASE);
   localparam logic signed [VAL_W-1:0] STEP_VAL = VAL_W'(INIT_STEP);

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        ptr_q, ptr_d;
   // Running sum replaces BASE + STEP*ptr, so no multiplier is needed.
   logic signed [VAL_W-1:0]  val_q, val_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
         val_q   <= BASE_VAL;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         val_q   <= val_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      val_d     = val_q;
      init_we   = 1'b0;
      init_done = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (INIT_LEN == 0) begin
               state_d = ST_RUN;
            end else begin
               init_we = ~reset;
               if (ptr_q == LAST_PTR) begin
                  init_done = ~reset;
                  state_d   = ST_RUN;
                  ptr_d     = '0;
                  val_d     = BASE_VAL;
               end else begin
                  ptr_d = ptr_q + 1'b1;
                  val_d = val_q + STEP_VAL;
               end
            end
         end
         ST_RUN: begin
            if (init_req) begin
               state_d = ST_INIT;
               ptr_d   = '0;
               val_d   = BASE_VAL;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign ready     = (state_q == ST_RUN);
   assign init_addr = START_ADDR + ptr_q;
   assign init_data = val_q[DATA_W-1:0];

endmodule

`default_nettype wire

// File: rtl/param_ram_init.sv
// +--------------------------------------------------------------------+
// | param_ram_init: 1R/1W synchronous RAM with built-in ramp preload   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module param_ram_init
   import ram_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int DEPTH      = 1024,
   parameter int ADDR_W     = clog2(DEPTH),
   parameter int INIT_START = 10,
   parameter int INIT_LEN   = 50,
   parameter int INIT_BASE  = -250,
   parameter int INIT_STEP  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init_req,
   output logic              ready,
   output logic              init_done,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data
);

   generate
      if (INIT_START + INIT_LEN > DEPTH) begin : g_bad_init_range
         $error("param_ram_init: INIT_START+INIT_LEN exceeds DEPTH");
      end
   endgenerate

   localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              w_init_we;
   logic [ADDR_W-1:0] w_init_addr;
   logic [DATA_W-1:0] w_init_data;
   logic              w_wr_in_range, w_rd_in_range;
   logic              w_user_wr, w_user_rd;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   ram_init_seq #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .INIT_START (INIT_START),
      .INIT_LEN   (INIT_LEN),
      .INIT_BASE  (INIT_BASE),
      .INIT_STEP  (INIT_STEP)
   ) u_init_seq (
      .clk       (clk),
      .reset     (reset),
      .init_req  (init_req),
      .ready     (ready),
      .init_done (init_done),
      .init_we   (w_init_we),
      .init_addr (w_init_addr),
      .init_data (w_init_data)
   );

   // DEPTH need not be a power of two, so the address space can exceed the array.
   assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_CMP);
   assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_CMP);
   assign w_user_wr     = ready & wr_en & w_wr_in_range & ~reset;
   assign w_user_rd     = ready & rd_en & ~reset;

   // Init and user writes are mutually exclusive: user ops only pass in RUN.
   always_ff @(posedge clk) begin
      if (w_init_we) begin
         mem_q[w_init_addr] <= w_init_data;
      end else if (w_user_wr) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      if (w_user_rd) begin
         rd_valid_d = 1'b1;
         if (!w_rd_in_range) begin
            rd_data_d = '0;
         end else if (w_user_wr && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
         end else begin
            rd_data_d = mem_q[rd_addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_param_ram_init.sv
// +--------------------------------------------------------------------+
// | tb_param_ram_init: scoreboard bench for param_ram_init             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_param_ram_init;

   // Non-power-of-two depth makes address DEPTH reachable on a 10-bit port.
   localparam int DATA_W = 16;
   localparam int DEPTH  = 1000;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              init_req = 1'b0;
   logic              ready, init_done, rd_valid;
   logic              wr_en = 1'b0, rd_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic [DATA_W-1:0] rd_data;

   logic              init_req8 = 1'b0, wr_en8 = 1'b0, rd_en8 = 1'b0;
   logic [9:0]        wr_addr8 = '0, rd_addr8 = '0;
   logic [7:0]        wr_data8 = '0;
   logic              ready8, init_done8, rd_valid8;
   logic [7:0]        rd_data8;

   typedef struct {
      logic [15:0] data;
      bit          care;
   } exp_t;

   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        sb_q[$];
   exp_t        sb_e;
   logic [15:0] model [int];
   int          low, dones;

   always #5 clk = ~clk;

   param_ram_init #(
      .DATA_W (DATA_W), .DEPTH (DEPTH), .ADDR_W (ADDR_W),
      .INIT_START (10), .INIT_LEN (50), .INIT_BASE (-250), .INIT_STEP (10)
   ) dut (
      .clk (clk), .reset (reset), .init_req (init_req),
      .ready (ready), .init_done (init_done),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .rd_en (rd_en), .rd_addr (rd_addr),
      .rd_valid (rd_valid), .rd_data (rd_data)
   );

   param_ram_init #(
      .DATA_W (8), .DEPTH (1024),
      .INIT_START (10), .INIT_LEN (50), .INIT_BASE (-250), .INIT_STEP (10)
   ) dut8 (
      .clk (clk), .reset (reset), .init_req (init_req8),
      .ready (ready8), .init_done (init_done8),
      .wr_en (wr_en8), .wr_addr (wr_addr8), .wr_data (wr_data8),
      .rd_en (rd_en8), .rd_addr (rd_addr8),
      .rd_valid (rd_valid8), .rd_data (rd_data8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic load_ramp();
      int v;
      for (int i = 0; i < 50; i++) begin
         v = -250 + 10 * i;
         model[10 + i] = v[15:0];
      end
   endtask

   // One RUN-state cycle of user traffic; called and returning on a negedge.
   task automatic op(input bit we, input logic [9:0] wa, input logic [15:0] wd,
                     input bit re, input logic [9:0] ra);
      exp_t e;
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_en = re; rd_addr = ra;
      if (re) begin
         e.care = 1'b1;
         if (int'(ra) >= DEPTH)                   e.data = 16'h0000;
         else if (we && wa == ra)                 e.data = wd;
         else if (model.exists(int'(ra)))         e.data = model[int'(ra)];
         else begin e.care = 1'b0; e.data = 16'h0000; end
         sb_q.push_back(e);
      end
      if (we && int'(wa) < DEPTH) model[int'(wa)] = wd;
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      if (re) check("rd_valid_lat1", 32'(rd_valid), 32'd1);
   endtask

   // Counts ready-low cycles and init_done pulses; optionally pokes ops mid-init.
   task automatic wait_init(input bit poke, output int n_low, output int n_done);
      n_low = 0; n_done = 0;
      while (!ready && n_low < 200) begin
         if (init_done) n_done++;
         if (poke && n_low == 3) begin
            rd_en = 1'b1; rd_addr = 10'd10;
            wr_en = 1'b1; wr_addr = 10'd100; wr_data = 16'h2222;
            init_req = 1'b1;
         end
         n_low++;
         @(negedge clk);
         if (poke && n_low == 4) begin
            rd_en = 1'b0; wr_en = 1'b0; init_req = 1'b0;
            check("no_rd_valid_in_init", 32'(rd_valid), 32'd0);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset && rd_valid) begin
         if (sb_q.size() == 0) begin
            check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
         end else begin
            sb_e = sb_q.pop_front();
            if (sb_e.care) check("rd_data", 32'(rd_data), 32'(sb_e.data));
            else           check("rd_data_known", 32'($isunknown(rd_data)), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready",     32'(ready),     32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_rd_valid",  32'(rd_valid),  32'd0);
      check("rst_rd_data",   32'(rd_data),   32'd0);
      reset = 1'b0;

      wait_init(1'b0, low, dones);
      check("init_ready_low_cycles", 32'(low), 32'd50);
      check("init_done_pulses",      32'(dones), 32'd1);
      load_ramp();

      op(0, 10'd0, 16'h0, 1, 10'd10);
      op(0, 10'd0, 16'h0, 1, 10'd11);
      op(0, 10'd0, 16'h0, 1, 10'd59);

      // 8-bit instance: ramp truncates to DATA_W.
      rd_en8 = 1'b1; rd_addr8 = 10'd10;
      @(negedge clk);
      check("w8_rd_valid",  32'(rd_valid8), 32'd1);
      check("w8_mem10",     32'(rd_data8),  32'h06);
      rd_addr8 = 10'd59;
      @(negedge clk);
      check("w8_mem59",     32'(rd_data8),  32'hF0);
      rd_en8 = 1'b0;

      op(1, 10'd5,   16'hBEEF, 0, 10'd0);
      op(0, 10'd0,   16'h0,    1, 10'd5);
      op(0, 10'd0,   16'h0,    1, 10'd4);
      op(1, 10'd100, 16'h1111, 0, 10'd0);
      op(1, 10'd7,   16'h1234, 1, 10'd7);

      op(1, 10'd0,   16'h0F0F, 0, 10'd0);
      op(1, 10'(DEPTH), 16'hAAAA, 0, 10'd0);
      op(0, 10'd0,   16'h0,    1, 10'd0);
      op(0, 10'd0,   16'h0,    1, 10'(DEPTH));

      op(1, 10'd20,  16'h5555, 0, 10'd0);
      op(0, 10'd0,   16'h0,    1, 10'd20);
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      wait_init(1'b1, low, dones);
      check("reinit_ready_low_cycles", 32'(low), 32'd50);
      check("reinit_done_pulses",      32'(dones), 32'd1);
      load_ramp();
      op(0, 10'd0, 16'h0, 1, 10'd20);
      op(0, 10'd0, 16'h0, 1, 10'd100);

      // Reset in the middle of an init restarts it from the first word.
      op(1, 10'd12, 16'h7777, 0, 10'd0);
      op(1, 10'd55, 16'h8888, 0, 10'd0);
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      repeat (25) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_rd_valid", 32'(rd_valid), 32'd0);
      wait_init(1'b0, low, dones);
      check("midrst_ready_low_cycles", 32'(low), 32'd50);
      check("midrst_done_pulses",      32'(dones), 32'd1);
      load_ramp();
      op(0, 10'd0, 16'h0, 1, 10'd12);
      op(0, 10'd0, 16'h0, 1, 10'd55);
      op(0, 10'd0, 16'h0, 1, 10'd100);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
